// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg: shared MDU operation codes, state encodings and helpers
package mdu_sequencer_pkg;

    typedef enum logic [2:0] {
        MDU_NONE,
        MDU_MULT,
        MDU_MULTU,
        MDU_DIV,
        MDU_DIVU,
        MDU_MTHI,
        MDU_MTLO
    } mdu_op_t;

    localparam int MDU_DIV_STEPS = 32;

    typedef logic [1:0] mdu_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: 32-step unsigned restoring divider core, magnitudes only
module mdu_divider
    import mdu_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        resetN,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        valid
);

    logic [31:0] d;
    logic [4:0]  n;
    logic        run;
    logic [33:0] trial;

    // remainder < divisor always holds, so the shifted remainder fits 33 bits and bit 33 is the borrow
    assign trial = {1'b0, remainder, quotient[31]} - {2'b0, d};

    // load on start, then one shift/subtract step per cycle; valid marks the cycle after the last step
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            quotient  <= '0;
            remainder <= '0;
            d         <= '0;
            n         <= '0;
            run       <= 1'b0;
            valid     <= 1'b0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            d         <= divisor;
            n         <= 5'(MDU_DIV_STEPS - 1);
            run       <= 1'b1;
            valid     <= 1'b0;
        end else if (run) begin
            quotient  <= {quotient[30:0], ~trial[33]};
            remainder <= trial[33] ? {remainder[30:0], quotient[31]} : trial[31:0];
            n         <= n - 5'd1;
            run       <= |n;
            valid     <= ~|n;
        end else begin
            valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide sequencer owning the HI/LO registers
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 5
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        start,
    input  mdu_op_t     mduOp,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_signed;
    logic        quo_neg;
    logic        rem_neg;
    logic        is_mul;
    logic        is_div;
    logic        div_signed;
    logic        div_start;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_valid;

    assign is_mul     = mduOp == MDU_MULT || mduOp == MDU_MULTU;
    assign is_div     = mduOp == MDU_DIV || mduOp == MDU_DIVU;
    assign div_signed = mduOp == MDU_DIV;
    assign div_start  = start && state == ST_IDLE && is_div;
    assign busy       = state != ST_IDLE;

    // low 64 bits of a 64x64 product of extended operands give the signed or unsigned 32x32 result
    assign ext_a   = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'b0, mul_a};
    assign ext_b   = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'b0, mul_b};
    assign product = ext_a * ext_b;

    mdu_divider u_div (
        .clock     (clock),
        .resetN    (resetN),
        .start     (div_start),
        .dividend  (mag(operandA, div_signed)),
        .divisor   (mag(operandB, div_signed)),
        .quotient  (quotient),
        .remainder (remainder),
        .valid     (div_valid)
    );

    // FSM: launch from IDLE, count down the multiplier, step the divider, then apply the sign fix-up
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            quo_neg    <= 1'b0;
            rem_neg    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    if (is_mul) begin
                        mul_a      <= operandA;
                        mul_b      <= operandB;
                        mul_signed <= mduOp == MDU_MULT;
                        cnt        <= 5'(MULT_CYCLES - 1);
                        state      <= ST_MUL;
                    end
                    // a zero divisor keeps the quotient all-ones and the remainder equal to the dividend
                    if (is_div) begin
                        rem_neg <= div_signed & operandA[31];
                        quo_neg <= div_signed & (operandA[31] ^ operandB[31]) & |operandB;
                        cnt     <= 5'(MDU_DIV_STEPS - 1);
                        state   <= ST_DIV;
                    end
                    if (mduOp == MDU_MTHI) hi <= operandA;
                    if (mduOp == MDU_MTLO) lo <= operandA;
                end
                ST_MUL: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        {hi, lo} <= product;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) state <= ST_FIX;
                end
                ST_FIX: if (div_valid) begin
                    lo    <= quo_neg ? -quotient : quotient;
                    hi    <= rem_neg ? -remainder : remainder;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed table-driven bench for the MDU sequencer
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        resetN = 1'b1;
    logic        start = 1'b0;
    mdu_op_t     mduOp = MDU_NONE;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    mdu_sequencer #(.MULT_CYCLES(5)) dut (
        .clock    (clock),
        .resetN   (resetN),
        .start    (start),
        .mduOp    (mduOp),
        .operandA (operandA),
        .operandB (operandB),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // drive start for one edge, then scramble operands to prove they were latched
    task automatic launch(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; mduOp = op; operandA = a; operandB = b;
        @(negedge clock);
        start = 1'b0; mduOp = MDU_NONE; operandA = 32'hdead_beef; operandB = 32'h0bad_f00d;
    endtask

    // count busy cycles (bounded) and done pulses until busy is observed low
    task automatic wait_low(output int bc, output int dc);
        bc = 0; dc = 0;
        while (busy && bc < 100) begin
            bc++;
            dc += int'(done);
            @(negedge clock);
        end
    endtask

    task automatic run_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          output int bc, output int dc);
        launch(op, a, b);
        wait_low(bc, dc);
        dc += int'(done);
        @(negedge clock);
        dc += int'(done);
    endtask

    initial begin
        int bc, dc, bc2, dc2;
        vt[0]  = '{MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vt[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vt[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vt[3]  = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33};
        vt[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vt[5]  = '{MDU_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 33};
        vt[6]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vt[7]  = '{MDU_DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 33};
        vt[8]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vt[9]  = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
        vt[10] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

        #2 resetN = 1'b0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, bc, dc);
            check($sformatf("v%0d hi", i), hi, vt[i].hi);
            check($sformatf("v%0d lo", i), lo, vt[i].lo);
            check($sformatf("v%0d busy_cycles", i), 32'(bc), 32'(vt[i].cyc));
            check($sformatf("v%0d done_pulses", i), 32'(dc), 32'd1);
        end

        launch(MDU_MTHI, 32'h00001234, 32'h0);
        check("mthi hi", hi, 32'h00001234);
        check("mthi lo", lo, 32'h00000001);
        check("mthi busy", 32'(busy), 32'd0);
        check("mthi done", 32'(done), 32'd0);
        launch(MDU_MTLO, 32'hCAFEF00D, 32'h0);
        check("mtlo lo", lo, 32'hCAFEF00D);
        check("mtlo hi", hi, 32'h00001234);
        check("mtlo busy", 32'(busy), 32'd0);

        launch(MDU_DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clock);
        start = 1'b1; mduOp = MDU_MTLO; operandA = 32'h55555555;
        @(negedge clock);
        start = 1'b0; mduOp = MDU_NONE;
        check("ignored mtlo lo mid", lo, 32'hCAFEF00D);
        wait_low(bc, dc);
        check("ignored mtlo div lo", lo, 32'd14);
        check("ignored mtlo div hi", hi, 32'd2);
        check("ignored mtlo busy_cycles", 32'(bc), 32'd29);

        launch(MDU_MULT, 32'd3, 32'hFFFFFFFB);
        wait_low(bc, dc);
        dc += int'(done);
        check("b2b mult hi", hi, 32'hFFFFFFFF);
        check("b2b mult lo", lo, 32'hFFFFFFF1);
        check("b2b mult busy_cycles", 32'(bc), 32'd5);
        start = 1'b1; mduOp = MDU_DIVU; operandA = 32'd100; operandB = 32'd9;
        @(negedge clock);
        start = 1'b0; mduOp = MDU_NONE; operandA = '0; operandB = '0;
        wait_low(bc2, dc2);
        dc += dc2 + int'(done);
        @(negedge clock);
        dc += int'(done);
        check("b2b divu lo", lo, 32'd11);
        check("b2b divu hi", hi, 32'd1);
        check("b2b divu busy_cycles", 32'(bc2), 32'd33);
        check("b2b done_pulses", 32'(dc), 32'd2);

        launch(MDU_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clock);
        check("pre-reset busy", 32'(busy), 32'd1);
        resetN = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset hi", hi, 32'd0);
        check("midreset lo", lo, 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        run_op(MDU_MULTU, 32'd3, 32'd4, bc, dc);
        check("post-reset lo", lo, 32'd12);
        check("post-reset hi", hi, 32'd0);
        check("post-reset busy_cycles", 32'(bc), 32'd5);
        check("post-reset done_pulses", 32'(dc), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
